// File: rtl/gshare_pkg.sv
// rtl/gshare_pkg.sv - shared FSM encoding and constants for the gshare predictor
package gshare_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int MISPRED_CNT_W = 16;

   // Weakly-not-taken is the value just below the counter midpoint.
   function automatic logic [3:0] weak_not_taken(input int cnt_w);
      return 4'((1 << (cnt_w - 1)) - 1);
   endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter_update.sv
// rtl/gshare_predictor_sat_counter_update.sv - next value of a saturating up/down counter
module sat_counter_update #(
   parameter int CNT_W = 2
) (
   input  logic [CNT_W-1:0] cnt,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt_next
);

   always_comb begin
      cnt_next = cnt;
      if (inc) begin
         if (cnt != '1) cnt_next = cnt + CNT_W'(1);
      end else begin
         if (cnt != '0) cnt_next = cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor with optional BTB
// Optional BTB is enabled by defining GSHARE_PREDICTOR_BTB_EN.
module gshare_predictor
   import gshare_pkg::*;
#(
   parameter int PC_W      = 16,
   parameter int IDX_W     = 8,
   parameter int HIST_W    = 8,
   parameter int CNT_W     = 2,
   parameter int BTB_IDX_W = 4
) (
   input  logic                     CLK,
   input  logic                     RES,
   input  logic                     predict_valid,
   input  logic [PC_W-1:0]          predict_pc,
   output logic                     predict_taken,
   output logic [HIST_W-1:0]        predict_history,
   output logic                     predict_ready,
   input  logic                     train_valid,
   input  logic                     train_taken,
   input  logic                     train_mispredicted,
   input  logic [HIST_W-1:0]        train_history,
   input  logic [PC_W-1:0]          train_pc,
   input  logic [PC_W-1:0]          train_target,
   output logic                     predict_hit,
   output logic [PC_W-1:0]          predict_target,
   output logic [MISPRED_CNT_W-1:0] mispredict_count
);

   localparam int PHT_N = 1 << IDX_W;
   localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(weak_not_taken(CNT_W));

   state_t                  state;
   logic [IDX_W-1:0]        init_ptr;
   logic [HIST_W-1:0]       history;
   logic [CNT_W-1:0]        pht [PHT_N];

   logic                    run;
   logic [IDX_W-1:0]        pred_idx;
   logic [IDX_W-1:0]        train_idx;
   logic [CNT_W-1:0]        pred_cnt;
   logic [CNT_W-1:0]        train_cnt;
   logic [CNT_W-1:0]        train_cnt_next;
   logic [HIST_W-1:0]       hist_from_train;
   logic [HIST_W-1:0]       hist_from_pred;
   logic                    train_mispred;
   logic                    unused_ok;

   assign run           = (state == ST_RUN);
   assign pred_idx      = predict_pc[IDX_W-1:0] ^ IDX_W'(history);
   assign train_idx     = train_pc[IDX_W-1:0] ^ IDX_W'(train_history);
   assign pred_cnt      = pht[pred_idx];
   assign train_cnt     = pht[train_idx];
   assign train_mispred = train_valid & train_mispredicted;

   assign predict_ready   = run;
   assign predict_taken   = predict_valid & run & pred_cnt[CNT_W-1];
   assign predict_history = history;

   assign unused_ok = ^{predict_pc, train_pc, train_target};

   sat_counter_update #(
      .CNT_W(CNT_W)
   ) u_sat (
      .cnt      (train_cnt),
      .inc      (train_taken),
      .cnt_next (train_cnt_next)
   );

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         state    <= ST_INIT;
         init_ptr <= '0;
      end else if (state == ST_INIT) begin
         init_ptr <= init_ptr + IDX_W'(1);
         if (init_ptr == '1) state <= ST_RUN;
      end
   end

   // PHT has no reset; only the INIT sweep gives it known contents.
   always_ff @(posedge CLK) begin
      if (state == ST_INIT) begin
         pht[init_ptr] <= WEAK_NT;
      end else if (train_valid) begin
         pht[train_idx] <= train_cnt_next;
      end
   end

   generate
      if (HIST_W == 1) begin : g_hist_1
         assign hist_from_train = train_taken;
         assign hist_from_pred  = predict_taken;
      end else begin : g_hist_n
         assign hist_from_train = {train_history[HIST_W-2:0], train_taken};
         assign hist_from_pred  = {history[HIST_W-2:0], predict_taken};
      end
   endgenerate

   // A mispredict repairs history from the training snapshot, overriding speculation.
   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         history <= '0;
      end else if (run) begin
         if (train_mispred) history <= hist_from_train;
         else if (predict_valid) history <= hist_from_pred;
      end
   end

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         mispredict_count <= '0;
      end else if (run && train_mispred && mispredict_count != '1) begin
         mispredict_count <= mispredict_count + MISPRED_CNT_W'(1);
      end
   end

`ifdef GSHARE_PREDICTOR_BTB_EN
   localparam int BTB_N = 1 << BTB_IDX_W;
   localparam int TAG_W = PC_W - BTB_IDX_W;

   logic [BTB_N-1:0]     btb_valid;
   logic [TAG_W-1:0]     btb_tag    [BTB_N];
   logic [PC_W-1:0]      btb_target [BTB_N];
   logic [BTB_IDX_W-1:0] btb_widx;
   logic [BTB_IDX_W-1:0] btb_ridx;
   logic                 btb_we;

   assign btb_widx = train_pc[BTB_IDX_W-1:0];
   assign btb_ridx = predict_pc[BTB_IDX_W-1:0];
   assign btb_we   = run & train_valid & train_taken;

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         btb_valid <= '0;
      end else if (btb_we) begin
         btb_valid[btb_widx] <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (btb_we) begin
         btb_tag[btb_widx]    <= train_pc[PC_W-1:BTB_IDX_W];
         btb_target[btb_widx] <= train_target;
      end
   end

   assign predict_hit    = predict_valid & run & btb_valid[btb_ridx] &
                           (btb_tag[btb_ridx] == predict_pc[PC_W-1:BTB_IDX_W]);
   assign predict_target = predict_hit ? btb_target[btb_ridx] : '0;
`else
   assign predict_hit    = 1'b0;
   assign predict_target = '0;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - self-checking bench for gshare_predictor
module tb_gshare_predictor;

   logic        CLK = 1'b0;
   logic        RES = 1'b0;
   logic        predict_valid;
   logic [15:0] predict_pc;
   logic        predict_taken;
   logic [7:0]  predict_history;
   logic        predict_ready;
   logic        train_valid;
   logic        train_taken;
   logic        train_mispredicted;
   logic [7:0]  train_history;
   logic [15:0] train_pc;
   logic [15:0] train_target;
   logic        predict_hit;
   logic [15:0] predict_target;
   logic [15:0] mispredict_count;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_v;
   logic        tk;
   logic        hit;
   logic [15:0] tgt;

   gshare_predictor #(
      .PC_W(16), .IDX_W(8), .HIST_W(8), .CNT_W(2), .BTB_IDX_W(4)
   ) dut (
      .CLK                (CLK),
      .RES                (RES),
      .predict_valid      (predict_valid),
      .predict_pc         (predict_pc),
      .predict_taken      (predict_taken),
      .predict_history    (predict_history),
      .predict_ready      (predict_ready),
      .train_valid        (train_valid),
      .train_taken        (train_taken),
      .train_mispredicted (train_mispredicted),
      .train_history      (train_history),
      .train_pc           (train_pc),
      .train_target       (train_target),
      .predict_hit        (predict_hit),
      .predict_target     (predict_target),
      .mispredict_count   (mispredict_count)
   );

   always #5 CLK = ~CLK;

   task automatic idle();
      predict_valid = 0; predict_pc = 0;
      train_valid = 0; train_taken = 0; train_mispredicted = 0;
      train_history = 0; train_pc = 0; train_target = 0;
   endtask

   task automatic train_cycle(input logic [15:0] pc, input logic [7:0] hist,
                              input logic taken, input logic mis, input logic [15:0] target);
      @(negedge CLK);
      idle();
      train_valid = 1; train_pc = pc; train_history = hist;
      train_taken = taken; train_mispredicted = mis; train_target = target;
      @(posedge CLK);
      #1 idle();
   endtask

   // Predict request held only long enough to sample; dropped before the edge.
   task automatic probe(input logic [15:0] pc, output logic o_tk, output logic o_hit,
                        output logic [15:0] o_tgt);
      @(negedge CLK);
      idle();
      predict_valid = 1; predict_pc = pc;
      #1;
      o_tk = predict_taken; o_hit = predict_hit; o_tgt = predict_target;
      predict_valid = 0;
   endtask

   task automatic test_reset();
      idle();
      RES = 0; predict_valid = 1; predict_pc = 16'h0012;
      repeat (3) @(negedge CLK);
      #1;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_ready) !== exp_v) begin miscompares++; $display("FAIL reset_ready: got %0h expected %0h", predict_ready, exp_v); end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_taken) !== exp_v) begin miscompares++; $display("FAIL reset_taken: got %0h expected %0h", predict_taken, exp_v); end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_hit) !== exp_v) begin miscompares++; $display("FAIL reset_hit: got %0h expected %0h", predict_hit, exp_v); end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_history) !== exp_v) begin miscompares++; $display("FAIL reset_history: got %0h expected %0h", predict_history, exp_v); end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(mispredict_count) !== exp_v) begin miscompares++; $display("FAIL reset_count: got %0h expected %0h", mispredict_count, exp_v); end
      idle();
   endtask

   task automatic test_reset_mid_init();
      @(negedge CLK);
      RES = 1;
      exp_q.push_back(32'd100);
      repeat (100) @(negedge CLK);
      #1;
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(dut.init_ptr) !== exp_v) begin miscompares++; $display("FAIL init_ptr_progress: got %0h expected %0h", dut.init_ptr, exp_v); end
      #1 RES = 0;
      exp_q.push_back(32'd0);
      #1;
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(dut.init_ptr) !== exp_v) begin miscompares++; $display("FAIL init_ptr_async_clear: got %0h expected %0h", dut.init_ptr, exp_v); end
   endtask

   task automatic test_init_sweep();
      int  low_cycles = 0;
      bit  seen_taken = 0;
      bit  done = 0;
      exp_q.push_back(32'd256); exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);   exp_q.push_back(32'd0);
      @(negedge CLK);
      RES = 1;
      for (int c = 0; c < 400 && !done; c++) begin
         if (c > 0) @(negedge CLK);
         predict_valid = 1; predict_pc = 16'(c * 37);
         train_valid = 1; train_mispredicted = 1; train_taken = 1;
         train_pc = 16'(c); train_history = 8'hFF;
         #1;
         if (predict_ready) begin
            done = 1;
            idle();
         end else begin
            low_cycles++;
            if (predict_taken !== 1'b0) seen_taken = 1;
         end
      end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(low_cycles) !== exp_v) begin miscompares++; $display("FAIL init_length: got %0d cycles expected %0d", low_cycles, exp_v); end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(seen_taken) !== exp_v) begin miscompares++; $display("FAIL init_taken_low: got %0h expected %0h", seen_taken, exp_v); end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_history) !== exp_v) begin miscompares++; $display("FAIL init_history_held: got %0h expected %0h", predict_history, exp_v); end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(mispredict_count) !== exp_v) begin miscompares++; $display("FAIL init_train_ignored: got %0h expected %0h", mispredict_count, exp_v); end
   endtask

   // Counter at index 0x12 walks 1->2->3, down to 1, saturates high, then saturates low.
   task automatic test_direction();
      train_cycle(16'h0012, 8'h00, 1, 0, 16'h0);
      train_cycle(16'h0012, 8'h00, 1, 0, 16'h0);
      exp_q.push_back(32'd1);
      probe(16'h0012, tk, hit, tgt);
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(tk) !== exp_v) begin miscompares++; $display("FAIL taken_after_two_taken: got %0h expected %0h", tk, exp_v); end
      exp_q.push_back(32'd0);
      #0;
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_history) !== exp_v) begin miscompares++; $display("FAIL history_untouched: got %0h expected %0h", predict_history, exp_v); end
      train_cycle(16'h0012, 8'h00, 0, 0, 16'h0);
      exp_q.push_back(32'd1);
      probe(16'h0012, tk, hit, tgt);
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(tk) !== exp_v) begin miscompares++; $display("FAIL weakly_taken: got %0h expected %0h", tk, exp_v); end
      train_cycle(16'h0012, 8'h00, 0, 0, 16'h0);
      exp_q.push_back(32'd0);
      probe(16'h0012, tk, hit, tgt);
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(tk) !== exp_v) begin miscompares++; $display("FAIL weakly_not_taken: got %0h expected %0h", tk, exp_v); end
      repeat (4) train_cycle(16'h0012, 8'h00, 1, 0, 16'h0);
      train_cycle(16'h0012, 8'h00, 0, 0, 16'h0);
      exp_q.push_back(32'd1);
      probe(16'h0012, tk, hit, tgt);
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(tk) !== exp_v) begin miscompares++; $display("FAIL saturate_high: got %0h expected %0h", tk, exp_v); end
      repeat (4) train_cycle(16'h0012, 8'h00, 0, 0, 16'h0);
      train_cycle(16'h0012, 8'h00, 1, 0, 16'h0);
      exp_q.push_back(32'd0);
      probe(16'h0012, tk, hit, tgt);
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(tk) !== exp_v) begin miscompares++; $display("FAIL saturate_low: got %0h expected %0h", tk, exp_v); end
      train_cycle(16'h0012, 8'h00, 1, 0, 16'h0);
      exp_q.push_back(32'd1);
      probe(16'h0012, tk, hit, tgt);
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(tk) !== exp_v) begin miscompares++; $display("FAIL recover_taken: got %0h expected %0h", tk, exp_v); end
   endtask

   task automatic test_history_priority();
      train_cycle(16'h0040, 8'h02, 1, 1, 16'h0);
      exp_q.push_back(32'h05);
      @(negedge CLK); #1;
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_history) !== exp_v) begin miscompares++; $display("FAIL history_repair: got %0h expected %0h", predict_history, exp_v); end
      train_valid = 1; train_mispredicted = 1; train_taken = 1;
      train_history = 8'h05; train_pc = 16'h0040;
      predict_valid = 1; predict_pc = 16'h0000;
      exp_q.push_back(32'h0B); exp_q.push_back(32'd2);
      @(posedge CLK); #1 idle();
      @(negedge CLK); #1;
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_history) !== exp_v) begin miscompares++; $display("FAIL train_over_predict: got %0h expected %0h", predict_history, exp_v); end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(mispredict_count) !== exp_v) begin miscompares++; $display("FAIL count_two: got %0h expected %0h", mispredict_count, exp_v); end
      predict_valid = 1; predict_pc = 16'h0012;
      exp_q.push_back(32'd0); exp_q.push_back(32'h16);
      #1;
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_taken) !== exp_v) begin miscompares++; $display("FAIL predict_idx19: got %0h expected %0h", predict_taken, exp_v); end
      @(posedge CLK); #1 idle();
      @(negedge CLK); #1;
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_history) !== exp_v) begin miscompares++; $display("FAIL shift_not_taken: got %0h expected %0h", predict_history, exp_v); end
      predict_valid = 1; predict_pc = 16'h0004;
      exp_q.push_back(32'd1); exp_q.push_back(32'h2D);
      #1;
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_taken) !== exp_v) begin miscompares++; $display("FAIL predict_idx12: got %0h expected %0h", predict_taken, exp_v); end
      @(posedge CLK); #1 idle();
      @(negedge CLK); #1;
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_history) !== exp_v) begin miscompares++; $display("FAIL shift_taken: got %0h expected %0h", predict_history, exp_v); end
   endtask

   // History is 0x2D here; index 0x80 is still at its init value.
   task automatic test_same_index();
      @(negedge CLK);
      idle();
      predict_valid = 1; predict_pc = 16'h00AD;
      train_valid = 1; train_taken = 1; train_history = 8'h2D; train_pc = 16'h00AD;
      exp_q.push_back(32'd0);
      #1;
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_taken) !== exp_v) begin miscompares++; $display("FAIL same_cycle_pre_update: got %0h expected %0h", predict_taken, exp_v); end
      @(posedge CLK); #1 idle();
      exp_q.push_back(32'd1);
      probe(16'h00DA, tk, hit, tgt);
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(tk) !== exp_v) begin miscompares++; $display("FAIL next_cycle_post_update: got %0h expected %0h", tk, exp_v); end
   endtask

   task automatic test_count_saturation();
      @(negedge CLK);
      idle();
      train_valid = 1; train_mispredicted = 1; train_taken = 0;
      exp_q.push_back(32'hFFFE); exp_q.push_back(32'hFFFF);
      repeat (65532) @(posedge CLK);
      @(negedge CLK); #1;
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(mispredict_count) !== exp_v) begin miscompares++; $display("FAIL count_near_max: got %0h expected %0h", mispredict_count, exp_v); end
      repeat (8) @(posedge CLK);
      @(negedge CLK); #1;
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(mispredict_count) !== exp_v) begin miscompares++; $display("FAIL count_saturated: got %0h expected %0h", mispredict_count, exp_v); end
      idle();
   endtask

   task automatic test_reset_mid_run();
      train_cycle(16'h0040, 8'h02, 1, 1, 16'h0);
      @(negedge CLK);
      #2 RES = 0;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      #1;
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(mispredict_count) !== exp_v) begin miscompares++; $display("FAIL run_reset_count: got %0h expected %0h", mispredict_count, exp_v); end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(dut.init_ptr) !== exp_v) begin miscompares++; $display("FAIL run_reset_init_ptr: got %0h expected %0h", dut.init_ptr, exp_v); end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_history) !== exp_v) begin miscompares++; $display("FAIL run_reset_history: got %0h expected %0h", predict_history, exp_v); end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(predict_ready) !== exp_v) begin miscompares++; $display("FAIL run_reset_ready: got %0h expected %0h", predict_ready, exp_v); end
      test_init_sweep();
      exp_q.push_back(32'd0);
      probe(16'h0012, tk, hit, tgt);
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(tk) !== exp_v) begin miscompares++; $display("FAIL pht_reinitialised: got %0h expected %0h", tk, exp_v); end
   endtask

   task automatic test_btb();
      train_cycle(16'h1234, 8'h00, 1, 0, 16'h2000);
`ifdef GSHARE_PREDICTOR_BTB_EN
      exp_q.push_back(32'd1); exp_q.push_back(32'h2000);
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
`else
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
`endif
      probe(16'h1234, tk, hit, tgt);
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(hit) !== exp_v) begin miscompares++; $display("FAIL btb_hit: got %0h expected %0h", hit, exp_v); end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(tgt) !== exp_v) begin miscompares++; $display("FAIL btb_target: got %0h expected %0h", tgt, exp_v); end
      probe(16'h5234, tk, hit, tgt);
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(hit) !== exp_v) begin miscompares++; $display("FAIL btb_tag_miss: got %0h expected %0h", hit, exp_v); end
      exp_v = exp_q.pop_front(); vectors++;
      if (32'(tgt) !== exp_v) begin miscompares++; $display("FAIL btb_miss_target: got %0h expected %0h", tgt, exp_v); end
   endtask

   initial begin
      idle();
      test_reset();
      test_reset_mid_init();
      test_init_sweep();
      test_direction();
      test_history_priority();
      test_same_index();
      test_count_saturation();
      test_reset_mid_run();
      test_btb();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
